md_sequencer: RTL and testbench

Iterative signed multiply/divide sequencer that owns the HI/LO result path of the multi-cycle CPU. The control unit issues a one-cycle `start` with an opcode and two register operands. The sequencer then runs a fixed-length shift-add (multiply) or restoring-subtract (divide) schedule over its internal registers. It returns the 64-bit result as HI/LO values with matching write-enable pulses. The control unit holds in its multiply/divide state until `done`.

---
 rtl/md_sequencer.sv | 185 ++++++++++++++++++
 tb/tb_md_sequencer.sv | 256 +++++++++++++++++++++++++
 2 files changed

// File: rtl/md_sequencer.sv
// Iterative signed multiply/divide sequencer producing HI/LO results.
// Shift-add multiply and restoring divide over magnitudes, sign-fixed at the end.
module md_sequencer #(
  parameter int unsigned WIDTH = 32
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             op,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             busy,
  output logic             done,
  output logic [WIDTH-1:0] hi_out,
  output logic [WIDTH-1:0] lo_out,
  output logic             hi_enable,
  output logic             lo_enable,
  output logic             div_by_zero
);

  localparam int unsigned CNT_W = $clog2(WIDTH) + 1;

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_RUN,
    S_FIX,
    S_DONE
  } state_e;

  state_e             state_q, state_d;
  logic               op_q, op_d;
  logic [WIDTH-1:0]   a_q, a_d;
  logic [WIDTH-1:0]   b_q, b_d;
  logic [WIDTH-1:0]   hi_acc_q, hi_acc_d;
  logic [WIDTH-1:0]   lo_acc_q, lo_acc_d;
  logic [WIDTH-1:0]   mag_q, mag_d;
  logic [WIDTH-1:0]   hi_out_q, hi_out_d;
  logic [WIDTH-1:0]   lo_out_q, lo_out_d;
  logic [CNT_W-1:0]   cnt_q, cnt_d;
  logic               busy_q, busy_d;
  logic               done_q, done_d;
  logic               dbz_q, dbz_d;

  logic [WIDTH-1:0]   abs_a, abs_b;
  logic [WIDTH:0]     mul_sum;
  logic [WIDTH:0]     div_shift;
  logic               div_ge;
  logic               sign_diff;
  logic [2*WIDTH-1:0] prod_neg;

  // Next-state, datapath iteration and result capture
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    a_d       = a_q;
    b_d       = b_q;
    hi_acc_d  = hi_acc_q;
    lo_acc_d  = lo_acc_q;
    mag_d     = mag_q;
    hi_out_d  = hi_out_q;
    lo_out_d  = lo_out_q;
    cnt_d     = cnt_q;
    dbz_d     = 1'b0;

    abs_a     = a_q[WIDTH-1] ? -a_q : a_q;
    abs_b     = b_q[WIDTH-1] ? -b_q : b_q;
    sign_diff = a_q[WIDTH-1] ^ b_q[WIDTH-1];
    mul_sum   = {1'b0, hi_acc_q} + (lo_acc_q[0] ? {1'b0, mag_q} : '0);
    div_shift = {hi_acc_q, lo_acc_q[WIDTH-1]};
    div_ge    = div_shift >= {1'b0, mag_q};
    prod_neg  = -{hi_acc_q, lo_acc_q};

    case (state_q)
      S_IDLE: begin
        if (start) begin
          state_d = S_LOAD;
          op_d    = op;
          a_d     = a;
          b_d     = b;
        end
      end
      S_LOAD: begin
        cnt_d    = '0;
        hi_acc_d = '0;
        if (op_q) begin
          lo_acc_d = abs_a;
          mag_d    = abs_b;
        end else begin
          lo_acc_d = abs_b;
          mag_d    = abs_a;
        end
        if (op_q && (b_q == '0)) begin
          state_d  = S_DONE;
          hi_out_d = a_q;
          lo_out_d = '1;
          dbz_d    = 1'b1;
        end else begin
          state_d  = S_RUN;
        end
      end
      S_RUN: begin
        cnt_d = cnt_q + CNT_W'(1);
        if (op_q) begin
          // Restoring step: remainder in hi_acc, dividend shifts out of lo_acc as quotient shifts in
          if (div_ge) begin
            hi_acc_d = WIDTH'(div_shift - {1'b0, mag_q});
            lo_acc_d = {lo_acc_q[WIDTH-2:0], 1'b1};
          end else begin
            hi_acc_d = div_shift[WIDTH-1:0];
            lo_acc_d = {lo_acc_q[WIDTH-2:0], 1'b0};
          end
        end else begin
          hi_acc_d = mul_sum[WIDTH:1];
          lo_acc_d = {mul_sum[0], lo_acc_q[WIDTH-1:1]};
        end
        if (cnt_q == CNT_W'(WIDTH - 1)) begin
          state_d = S_FIX;
        end
      end
      S_FIX: begin
        state_d = S_DONE;
        if (op_q) begin
          lo_out_d = sign_diff ? -lo_acc_q : lo_acc_q;
          hi_out_d = a_q[WIDTH-1] ? -hi_acc_q : hi_acc_q;
        end else if (sign_diff) begin
          {hi_out_d, lo_out_d} = prod_neg;
        end else begin
          hi_out_d = hi_acc_q;
          lo_out_d = lo_acc_q;
        end
      end
      S_DONE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    done_d = (state_d == S_DONE);
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q  <= S_IDLE;
      op_q     <= 1'b0;
      a_q      <= '0;
      b_q      <= '0;
      hi_acc_q <= '0;
      lo_acc_q <= '0;
      mag_q    <= '0;
      hi_out_q <= '0;
      lo_out_q <= '0;
      cnt_q    <= '0;
      busy_q   <= 1'b0;
      done_q   <= 1'b0;
      dbz_q    <= 1'b0;
    end else begin
      state_q  <= state_d;
      op_q     <= op_d;
      a_q      <= a_d;
      b_q      <= b_d;
      hi_acc_q <= hi_acc_d;
      lo_acc_q <= lo_acc_d;
      mag_q    <= mag_d;
      hi_out_q <= hi_out_d;
      lo_out_q <= lo_out_d;
      cnt_q    <= cnt_d;
      busy_q   <= busy_d;
      done_q   <= done_d;
      dbz_q    <= dbz_d;
    end
  end

  assign busy        = busy_q;
  assign done        = done_q;
  assign hi_out      = hi_out_q;
  assign lo_out      = lo_out_q;
  assign hi_enable   = done_q;
  assign lo_enable   = done_q;
  assign div_by_zero = dbz_q;

endmodule

// File: tb/tb_md_sequencer.sv
// Bench for md_sequencer: directed vector table, timing/abort sequences,
// and random operations checked against a signed-arithmetic reference model.
module tb_md_sequencer;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        start = 1'b0;
  logic        op = 1'b0;
  logic [31:0] a = '0;
  logic [31:0] b = '0;
  logic        busy, done, hi_enable, lo_enable, div_by_zero;
  logic [31:0] hi_out, lo_out;

  int checks = 0;
  int failures = 0;

  md_sequencer #(.WIDTH(32)) dut (
    .clk         (clk),
    .rst         (rst),
    .start       (start),
    .op          (op),
    .a           (a),
    .b           (b),
    .busy        (busy),
    .done        (done),
    .hi_out      (hi_out),
    .lo_out      (lo_out),
    .hi_enable   (hi_enable),
    .lo_enable   (lo_enable),
    .div_by_zero (div_by_zero)
  );

  always #5 clk = ~clk;

  typedef struct {
    bit          op;
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] hi;
    logic [31:0] lo;
    bit          dbz;
  } vec_t;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  // Reference: exact signed product; truncating signed divide with 64-bit operands
  function automatic void model(input bit o, input logic [31:0] av, input logic [31:0] bv,
                                output logic [31:0] hi, output logic [31:0] lo, output bit dbz);
    longint sa, sb, p, q, r;
    sa  = longint'($signed(av));
    sb  = longint'($signed(bv));
    dbz = 1'b0;
    if (!o) begin
      p  = sa * sb;
      hi = p[63:32];
      lo = p[31:0];
    end else if (bv == 32'h0) begin
      hi  = av;
      lo  = 32'hFFFF_FFFF;
      dbz = 1'b1;
    end else begin
      q  = sa / sb;
      r  = sa % sb;
      hi = r[31:0];
      lo = q[31:0];
    end
  endfunction

  // Issue one operation from IDLE and wait (bounded) for done; returns in the done cycle
  task automatic run_op(input bit o, input logic [31:0] av, input logic [31:0] bv,
                        output logic [31:0] hi, output logic [31:0] lo, output bit dbz,
                        output int lat, output int busy_cnt, output bit en_ok, output bit seen);
    hi = '0; lo = '0; dbz = 1'b0; lat = 0; busy_cnt = 0; en_ok = 1'b0; seen = 1'b0;
    start = 1'b1; op = o; a = av; b = bv;
    @(posedge clk); #1;
    start = 1'b0; op = 1'($urandom); a = $urandom; b = $urandom;
    for (int k = 0; k < 100; k++) begin
      if (busy) busy_cnt++;
      if (done) begin
        seen  = 1'b1;
        lat   = k + 1;
        hi    = hi_out;
        lo    = lo_out;
        dbz   = div_by_zero;
        en_ok = hi_enable && lo_enable;
        break;
      end
      @(posedge clk); #1;
    end
  endtask

  task automatic after_done(input string tag);
    @(posedge clk); #1;
    check({tag, " done low after"}, 64'(done), 64'(0));
    check({tag, " busy low after"}, 64'(busy), 64'(0));
  endtask

  vec_t        vecs[14];
  logic [31:0] r_hi, r_lo, m_hi, m_lo;
  bit          r_dbz, m_dbz, en_ok, seen;
  int          lat, bcnt;

  initial begin
    vecs[0]  = '{1'b0, 32'h0000_0007, 32'hFFFF_FFFD, 32'hFFFF_FFFF, 32'hFFFF_FFEB, 1'b0};
    vecs[1]  = '{1'b0, 32'h8000_0000, 32'h8000_0000, 32'h4000_0000, 32'h0000_0000, 1'b0};
    vecs[2]  = '{1'b1, 32'hFFFF_FFF9, 32'h0000_0002, 32'hFFFF_FFFF, 32'hFFFF_FFFD, 1'b0};
    vecs[3]  = '{1'b1, 32'h8000_0000, 32'hFFFF_FFFF, 32'h0000_0000, 32'h8000_0000, 1'b0};
    vecs[4]  = '{1'b1, 32'h0000_0005, 32'h0000_0000, 32'h0000_0005, 32'hFFFF_FFFF, 1'b1};
    vecs[5]  = '{1'b0, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 32'h0000_0000, 32'h0000_0001, 1'b0};
    vecs[6]  = '{1'b0, 32'h0000_0000, 32'h1234_5678, 32'h0000_0000, 32'h0000_0000, 1'b0};
    vecs[7]  = '{1'b1, 32'h0000_0007, 32'hFFFF_FFFE, 32'h0000_0001, 32'hFFFF_FFFD, 1'b0};
    vecs[8]  = '{1'b1, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 32'hFFFF_FFFF, 32'h0000_0003, 1'b0};
    vecs[9]  = '{1'b1, 32'h0000_0064, 32'h0000_0007, 32'h0000_0002, 32'h0000_000E, 1'b0};
    vecs[10] = '{1'b0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 32'h3FFF_FFFF, 32'h0000_0001, 1'b0};
    vecs[11] = '{1'b1, 32'h8000_0000, 32'h0000_0000, 32'h8000_0000, 32'hFFFF_FFFF, 1'b1};
    vecs[12] = '{1'b0, 32'h0001_0000, 32'h0001_0000, 32'h0000_0001, 32'h0000_0000, 1'b0};
    vecs[13] = '{1'b1, 32'h0000_0003, 32'h0000_0005, 32'h0000_0003, 32'h0000_0000, 1'b0};

    // Reset state
    repeat (3) @(posedge clk);
    #1;
    check("reset busy", 64'(busy), 64'(0));
    check("reset done", 64'(done), 64'(0));
    check("reset hi_out", 64'(hi_out), 64'(0));
    check("reset lo_out", 64'(lo_out), 64'(0));
    check("reset enables", 64'({hi_enable, lo_enable}), 64'(0));
    check("reset dbz", 64'(div_by_zero), 64'(0));
    rst = 1'b0;
    @(posedge clk); #1;

    // Directed vector table
    for (int i = 0; i < 14; i++) begin
      run_op(vecs[i].op, vecs[i].a, vecs[i].b, r_hi, r_lo, r_dbz, lat, bcnt, en_ok, seen);
      check($sformatf("vec%0d done seen", i), 64'(seen), 64'(1));
      check($sformatf("vec%0d hi", i), 64'(r_hi), 64'(vecs[i].hi));
      check($sformatf("vec%0d lo", i), 64'(r_lo), 64'(vecs[i].lo));
      check($sformatf("vec%0d dbz", i), 64'(r_dbz), 64'(vecs[i].dbz));
      check($sformatf("vec%0d enables", i), 64'(en_ok), 64'(1));
      check($sformatf("vec%0d latency", i), 64'(lat), vecs[i].dbz ? 64'(2) : 64'(35));
      check($sformatf("vec%0d busy cycles", i), 64'(bcnt), vecs[i].dbz ? 64'(2) : 64'(35));
      after_done($sformatf("vec%0d", i));
    end

    // Start pulses while busy (mid-RUN and during DONE) are ignored
    begin
      int d;
      int ndone;
      int busy_after;
      d = -1; ndone = 0; busy_after = 0;
      start = 1'b1; op = 1'b0; a = 32'h7; b = 32'hFFFF_FFFD;
      @(posedge clk); #1;
      start = 1'b0;
      for (int k = 0; k < 80; k++) begin
        if (k == 10) begin
          start = 1'b1; op = 1'b1; a = 32'h5; b = 32'h0;
        end else if (k == 11) begin
          start = 1'b0;
        end else if (d >= 0 && k == d + 1) begin
          start = 1'b0;
        end
        if (d >= 0 && k > d && busy) busy_after++;
        if (done) begin
          ndone++;
          if (d < 0) begin
            d = k; r_hi = hi_out; r_lo = lo_out;
          end
          start = 1'b1; op = 1'b1; a = 32'h9; b = 32'h3;
        end
        @(posedge clk); #1;
      end
      start = 1'b0;
      check("ignore done count", 64'(ndone), 64'(1));
      check("ignore latency", 64'(d + 1), 64'(35));
      check("ignore hi", 64'(r_hi), 64'hFFFF_FFFF);
      check("ignore lo", 64'(r_lo), 64'hFFFF_FFEB);
      check("ignore no restart", 64'(busy_after), 64'(0));
    end

    // Reset during RUN iteration 10 aborts silently
    begin
      int ndone;
      ndone = 0;
      start = 1'b1; op = 1'b0; a = 32'h3; b = 32'h4;
      @(posedge clk); #1;
      start = 1'b0;
      repeat (11) @(posedge clk);
      #1;
      check("abort busy before rst", 64'(busy), 64'(1));
      rst = 1'b1;
      @(posedge clk); #1;
      rst = 1'b0;
      check("abort busy", 64'(busy), 64'(0));
      check("abort done", 64'(done), 64'(0));
      check("abort hi_out", 64'(hi_out), 64'(0));
      check("abort lo_out", 64'(lo_out), 64'(0));
      for (int k = 0; k < 40; k++) begin
        if (done) ndone++;
        @(posedge clk); #1;
      end
      check("abort no done", 64'(ndone), 64'(0));
      run_op(1'b0, 32'h3, 32'h4, r_hi, r_lo, r_dbz, lat, bcnt, en_ok, seen);
      check("post-abort done seen", 64'(seen), 64'(1));
      check("post-abort lo", 64'(r_lo), 64'(12));
      check("post-abort hi", 64'(r_hi), 64'(0));
      check("post-abort latency", 64'(lat), 64'(35));
      after_done("post-abort");
    end

    // Reset wins over a simultaneous start
    begin
      int ndone;
      ndone = 0;
      rst = 1'b1; start = 1'b1; op = 1'b0; a = 32'h2; b = 32'h2;
      @(posedge clk); #1;
      rst = 1'b0; start = 1'b0;
      check("rst priority busy", 64'(busy), 64'(0));
      for (int k = 0; k < 40; k++) begin
        if (done) ndone++;
        @(posedge clk); #1;
      end
      check("rst priority no done", 64'(ndone), 64'(0));
    end

    // Random operations against the reference model
    for (int i = 0; i < 60; i++) begin
      bit          o;
      logic [31:0] av, bv;
      int          sel;
      o   = 1'($urandom_range(0, 1));
      av  = $urandom;
      bv  = $urandom;
      sel = $urandom_range(0, 7);
      if (sel == 0) bv = 32'h0;
      else if (sel == 1) av = 32'h8000_0000;
      else if (sel == 2) bv = 32'hFFFF_FFFF;
      else if (sel == 3) bv = 32'($urandom_range(0, 15));
      model(o, av, bv, m_hi, m_lo, m_dbz);
      run_op(o, av, bv, r_hi, r_lo, r_dbz, lat, bcnt, en_ok, seen);
      check($sformatf("rnd%0d op%0d a=%h b=%h hi", i, o, av, bv), 64'(r_hi), 64'(m_hi));
      check($sformatf("rnd%0d op%0d a=%h b=%h lo", i, o, av, bv), 64'(r_lo), 64'(m_lo));
      check($sformatf("rnd%0d dbz", i), 64'(r_dbz), 64'(m_dbz));
      check($sformatf("rnd%0d latency", i), 64'(lat), m_dbz ? 64'(2) : 64'(35));
      after_done($sformatf("rnd%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
